// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - functional-unit result and dual-CDB broadcast bundle
interface cdb_arbiter_if #(
    parameter int NUM_FU = 4,
    parameter int PKT_W  = 64
);
    logic [NUM_FU-1:0]            fu_valid;
    logic [NUM_FU-1:0][PKT_W-1:0] fu_pkt;
    logic [NUM_FU-1:0]            fu_ready;
    logic                         cdb_valid;
    logic [PKT_W-1:0]             cdb_pkt;
    logic                         cdb2_valid;
    logic [PKT_W-1:0]             cdb2_pkt;

    modport master (
        output fu_valid, fu_pkt,
        input  fu_ready, cdb_valid, cdb_pkt, cdb2_valid, cdb2_pkt
    );

    modport slave (
        input  fu_valid, fu_pkt,
        output fu_ready, cdb_valid, cdb_pkt, cdb2_valid, cdb2_pkt
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - two-port CDB arbiter, branch unit pinned to port 2
module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int PKT_W  = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    cdb_arbiter_if.slave   bus
);
    localparam int K  = NUM_FU - 1;
    localparam int PW = $clog2(NUM_FU);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] rr_next;
    logic          p1_hit, p2_hit;
    logic [PW-1:0] p1_idx, p2_idx;
    logic          p1_go, p2_go;

    // Requester index reached 'off' steps after 'base' in the circular 1..K order.
    function automatic logic [PW-1:0] cand(input logic [PW-1:0] base, input int off);
        int v;
        v = ((int'(base) - 1 + off) % K) + 1;
        return PW'(v);
    endfunction

    always_comb begin
        p1_hit = 1'b0;
        p1_idx = '0;
        for (int off = 0; off < K; off++) begin
            if (!p1_hit && bus.fu_valid[cand(rr_ptr, off)]) begin
                p1_hit = 1'b1;
                p1_idx = cand(rr_ptr, off);
            end
        end
    end

    // Branch unit owns port 2; otherwise port 2 continues the port-1 search.
    always_comb begin
        p2_hit = 1'b0;
        p2_idx = '0;
        if (bus.fu_valid[0]) begin
            p2_hit = 1'b1;
        end else if (p1_hit) begin
            for (int off = 1; off < K; off++) begin
                if (!p2_hit && bus.fu_valid[cand(p1_idx, off)]) begin
                    p2_hit = 1'b1;
                    p2_idx = cand(p1_idx, off);
                end
            end
        end
    end

    assign p1_go   = p1_hit && !flush;
    assign p2_go   = p2_hit && !flush;
    assign rr_next = (int'(p1_idx) == K) ? PW'(1) : p1_idx + PW'(1);

    always_comb begin
        bus.fu_ready = '0;
        if (rst) begin
            if (p1_go) bus.fu_ready[p1_idx] = 1'b1;
            if (p2_go) bus.fu_ready[p2_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr         <= PW'(1);
            bus.cdb_valid  <= 1'b0;
            bus.cdb_pkt    <= '0;
            bus.cdb2_valid <= 1'b0;
            bus.cdb2_pkt   <= '0;
        end else begin
            bus.cdb_valid  <= p1_go;
            bus.cdb2_valid <= p2_go;
            if (p1_go) begin
                bus.cdb_pkt <= bus.fu_pkt[p1_idx];
                rr_ptr      <= rr_next;
            end
            if (p2_go) bus.cdb2_pkt <= bus.fu_pkt[p2_idx];
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    cdb_arbiter_if #(.NUM_FU(4), .PKT_W(64)) bus ();

    cdb_arbiter #(.NUM_FU(4), .PKT_W(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Round-robin expectations for fu_valid=1110, rr_ptr starting at 1.
    logic [3:0]  rr_ready [3] = '{4'b0110, 4'b1100, 4'b1010};
    logic [63:0] rr_p1    [3] = '{64'h11, 64'h22, 64'h33};
    logic [63:0] rr_p2    [3] = '{64'h22, 64'h33, 64'h11};
    logic [1:0]  rr_seq   [3] = '{2'd2, 2'd3, 2'd1};
    logic [1:0]  all_rr   [3] = '{2'd1, 2'd2, 2'd3};

    initial begin
        rst          = 1'b0;
        flush        = 1'b0;
        bus.fu_valid = 4'b1111;
        bus.fu_pkt[0] = 64'h0;
        bus.fu_pkt[1] = 64'h11;
        bus.fu_pkt[2] = 64'h22;
        bus.fu_pkt[3] = 64'h33;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 64'(bus.fu_ready), 64'h0);
        chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        chk("rst_cdb2_valid", 64'(bus.cdb2_valid), 64'h0);
        chk("rst_cdb_pkt", bus.cdb_pkt, 64'h0);
        chk("rst_cdb2_pkt", bus.cdb2_pkt, 64'h0);
        chk("rst_rr", 64'(dut.rr_ptr), 64'd1);

        // Branch unit alone goes to port 2.
        @(negedge clk);
        rst = 1'b1;
        bus.fu_valid  = 4'b0001;
        bus.fu_pkt[0] = 64'hA;
        #1;
        chk("br_ready", 64'(bus.fu_ready), 64'h1);
        after_edge();
        chk("br_cdb2_valid", 64'(bus.cdb2_valid), 64'h1);
        chk("br_cdb2_pkt", bus.cdb2_pkt, 64'hA);
        chk("br_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        chk("br_rr", 64'(dut.rr_ptr), 64'd1);

        // Three-way round robin without the branch unit.
        @(negedge clk);
        bus.fu_valid = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("rr_ready%0d", i), 64'(bus.fu_ready), 64'(rr_ready[i]));
            after_edge();
            chk($sformatf("rr_cdb_valid%0d", i), 64'(bus.cdb_valid), 64'h1);
            chk($sformatf("rr_cdb_pkt%0d", i), bus.cdb_pkt, rr_p1[i]);
            chk($sformatf("rr_cdb2_valid%0d", i), 64'(bus.cdb2_valid), 64'h1);
            chk($sformatf("rr_cdb2_pkt%0d", i), bus.cdb2_pkt, rr_p2[i]);
            chk($sformatf("rr_ptr%0d", i), 64'(dut.rr_ptr), 64'(rr_seq[i]));
            @(negedge clk);
        end

        // All requesters: port 2 always branch, port 1 follows rr_ptr.
        bus.fu_valid  = 4'b1111;
        bus.fu_pkt[0] = 64'hA0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("all_ready%0d", i), 64'(bus.fu_ready),
                64'(4'b0001 | (4'b0001 << all_rr[i])));
            after_edge();
            chk($sformatf("all_cdb_pkt%0d", i), bus.cdb_pkt, 64'h11 * all_rr[i]);
            chk($sformatf("all_cdb2_pkt%0d", i), bus.cdb2_pkt, 64'hA0);
            @(negedge clk);
        end

        // One grant to requester 1 moves rr_ptr to 2, then flush.
        bus.fu_valid = 4'b0010;
        after_edge();
        chk("pre_flush_rr", 64'(dut.rr_ptr), 64'd2);
        @(negedge clk);
        flush        = 1'b1;
        bus.fu_valid = 4'b0110;
        #1;
        chk("flush_ready", 64'(bus.fu_ready), 64'h0);
        chk("flush_keeps_bcast", 64'(bus.cdb_valid), 64'h1);
        after_edge();
        chk("flush_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        chk("flush_cdb2_valid", 64'(bus.cdb2_valid), 64'h0);
        chk("flush_rr", 64'(dut.rr_ptr), 64'd2);
        chk("flush_pkt_hold", bus.cdb_pkt, 64'h11);

        // Requesters retry once flush drops: port1 req2, port2 req1.
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("retry_ready", 64'(bus.fu_ready), 64'h6);
        after_edge();
        chk("retry_cdb_pkt", bus.cdb_pkt, 64'h22);
        chk("retry_cdb2_pkt", bus.cdb2_pkt, 64'h11);
        chk("retry_rr", 64'(dut.rr_ptr), 64'd3);

        // Asynchronous reset between edges while a broadcast is live.
        #2;
        rst = 1'b0;
        #1;
        chk("arst_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        chk("arst_cdb2_valid", 64'(bus.cdb2_valid), 64'h0);
        chk("arst_rr", 64'(dut.rr_ptr), 64'd1);
        chk("arst_ready", 64'(bus.fu_ready), 64'h0);

        // First grant is available in the first cycle after reset release.
        @(negedge clk);
        rst          = 1'b1;
        bus.fu_valid = 4'b0010;
        #1;
        chk("post_rst_ready", 64'(bus.fu_ready), 64'h2);
        after_edge();
        chk("post_rst_cdb_valid", 64'(bus.cdb_valid), 64'h1);
        chk("post_rst_cdb_pkt", bus.cdb_pkt, 64'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
